// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell (two half adders + OR) and a
// carry flip-flop process the operands LSB-first, one bit per clock.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    count;

  logic             ha0_s;
  logic             ha0_c;
  logic             ha1_c;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_next;

  half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s),  .c(ha0_c));
  half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(fa_sum), .c(ha1_c));

  assign fa_cout = ha0_c | ha1_c;

  // Result bits collect in a private accumulator so the visible sum only
  // changes when a complete result is published.
  assign acc_next = acc | (WIDTH'(fa_sum) << count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b ^ {WIDTH{sub}};
            carry    <= sub ? 1'b1 : cin;
            count    <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          count <= count + 1'b1;
          acc   <= acc_next;
          // On the MSB, carry still holds the carry into the MSB.
          if (count == LAST) begin
            sum       <= acc_next;
            cout      <= fa_cout;
            ovf       <= carry ^ fa_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed WIDTH=4 vectors plus randomised WIDTH=1 and
// WIDTH=8 runs against an arithmetic reference model.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_v  [3];
  logic [7:0] a_v         [3];
  logic [7:0] b_v         [3];
  logic       cin_v       [3];
  logic       sub_v       [3];
  logic       out_ready_v [3];
  logic       in_ready_v  [3];
  logic       out_valid_v [3];
  logic       cout_v      [3];
  logic       ovf_v       [3];
  logic [3:0] sum4;
  logic [0:0] sum1;
  logic [7:0] sum8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum4), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum8), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  function automatic logic [7:0] sumOf(input int k);
    case (k)
      0:       return {4'b0, sum4};
      1:       return {7'b0, sum1};
      default: return sum8;
    endcase
  endfunction

  function automatic longint sx(input longint v, input int w);
    return v[w-1] ? v - (longint'(1) << w) : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; waits for in_ready, then presents one operand set.
  task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b,
                               input logic ci, input logic su);
    int n = 0;
    while (!in_ready_v[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("accept_timeout", 32'd0, 32'd1);
    a_v[k]        = a;
    b_v[k]        = b;
    cin_v[k]      = ci;
    sub_v[k]      = su;
    in_valid_v[k] = 1'b1;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  task automatic waitResult(input int k, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) checkOutput("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int k, input int stall);
    repeat (stall) @(negedge clk);
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
  endtask

  task automatic checkResult(input string tag, input int k, input logic [7:0] s,
                             input logic co, input logic ov);
    checkOutput(tag, {22'b0, sumOf(k), cout_v[k], ovf_v[k]}, {22'b0, s, co, ov});
  endtask

  // Reference arithmetic works on integers, independent of the bit-serial datapath.
  task automatic runRandom(input int k, input int w);
    longint     ua, ub, mask, full, sres;
    logic [7:0] s;
    logic       co, ov, ci, su;
    int         lat;
    mask = (longint'(1) << w) - 1;
    for (int i = 0; i < 500; i++) begin
      ua = longint'($urandom) & mask;
      ub = longint'($urandom) & mask;
      ci = 1'($urandom_range(0, 1));
      su = 1'($urandom_range(0, 1));
      if (su) begin
        full = (ua - ub) & mask;
        co   = (ua >= ub);
        sres = sx(ua, w) - sx(ub, w);
      end else begin
        full = ua + ub + longint'(ci);
        co   = full[w];
        full = full & mask;
        sres = sx(ua, w) + sx(ub, w) + longint'(ci);
      end
      s  = 8'(full);
      ov = (sres > (longint'(1) << (w - 1)) - 1) || (sres < -(longint'(1) << (w - 1)));
      applyStimulus(k, 8'(ua), 8'(ub), ci, su);
      waitResult(k, lat);
      checkResult($sformatf("rand_w%0d_%0d", w, i), k, s, co, ov);
      drain(k, $urandom_range(0, 3));
      checkOutput($sformatf("rand_w%0d_nodup_%0d", w, i), {31'b0, out_valid_v[k]}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k]  = 1'b0;
      a_v[k]         = '0;
      b_v[k]         = '0;
      cin_v[k]       = 1'b0;
      sub_v[k]       = 1'b0;
      out_ready_v[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkResult("reset_outputs", 0, 8'h0, 1'b0, 1'b0);
    checkOutput("reset_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
    rst = 1'b0;

    applyStimulus(0, 8'h7, 8'h1, 1'b0, 1'b0);
    checkOutput("t1_busy_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
    checkOutput("t1_busy_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
    waitResult(0, lat);
    checkOutput("t1_latency", 32'(lat), 32'd4);
    checkResult("t1_add_7_1", 0, 8'h8, 1'b0, 1'b1);
    drain(0, 0);
    checkOutput("t1_drain_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
    checkOutput("t1_drain_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    checkResult("t1_hold_after_drain", 0, 8'h8, 1'b0, 1'b1);

    applyStimulus(0, 8'hF, 8'h1, 1'b1, 1'b0);
    waitResult(0, lat);
    checkResult("t2_add_f_1_c1", 0, 8'h1, 1'b1, 1'b0);
    drain(0, 0);

    applyStimulus(0, 8'h3, 8'h5, 1'b1, 1'b1);
    waitResult(0, lat);
    checkResult("t3_sub_3_5", 0, 8'hE, 1'b0, 1'b0);
    drain(0, 1);

    applyStimulus(0, 8'h5, 8'h3, 1'b0, 1'b1);
    waitResult(0, lat);
    checkResult("t4_sub_5_3", 0, 8'h2, 1'b1, 1'b0);
    drain(0, 0);

    // Backpressure plus a stray in_valid pulse while the op is running.
    applyStimulus(0, 8'h6, 8'h5, 1'b0, 1'b0);
    a_v[0] = 8'hF; b_v[0] = 8'hF; sub_v[0] = 1'b1; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    waitResult(0, lat);
    checkResult("t5_add_6_5", 0, 8'hB, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_bp_valid_%0d", i), {31'b0, out_valid_v[0]}, 32'd1);
      checkResult($sformatf("t5_bp_result_%0d", i), 0, 8'hB, 1'b0, 1'b1);
    end
    drain(0, 0);
    @(negedge clk);
    checkOutput("t5_no_extra_op", {31'b0, out_valid_v[0]}, 32'd0);
    checkOutput("t5_idle_ready", {31'b0, in_ready_v[0]}, 32'd1);

    // Reset during the third RUN cycle aborts the op.
    applyStimulus(0, 8'h2, 8'h3, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_rst_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    checkOutput("t6_rst_out_valid", {31'b0, out_valid_v[0]}, 32'd0);
    checkResult("t6_rst_result", 0, 8'h0, 1'b0, 1'b0);
    applyStimulus(0, 8'h9, 8'h9, 1'b0, 1'b0);
    waitResult(0, lat);
    checkOutput("t6_latency", 32'(lat), 32'd4);
    checkResult("t6_add_9_9", 0, 8'h2, 1'b1, 1'b1);
    drain(0, 0);

    fork
      runRandom(1, 1);
      runRandom(2, 8);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
